// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
//   Inter-stage pipeline register with a ready/valid handshake, optional
//   2-entry skid buffer, synchronous flush to a NOP bubble, a saturating
//   stall counter and an unconditionally retimed PC-increment sideband.
//
//   state | meaning
//   EMPTY | nothing held; out_payload shows NOP_PAYLOAD
//   ONE   | head entry in main register
//   FULL  | head in main, next entry waiting in skid (SKID=1 only)
//
// Ports:
//   clk, rst (async active-low)
//   in_valid / in_ready / in_payload     upstream handshake
//   out_valid / out_ready / out_payload  downstream handshake
//   flush                                kill held and incoming entries
//   in_pcincr / out_pcincr               retimed sideband
//   stall_cnt / stall_clr                stall monitor
module pipeline_stage_reg #(
  parameter int                   PAYLOAD_W   = 96,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter bit                   SKID        = 1'b1,
  parameter int                   CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush,
  input  logic                 in_pcincr,
  output logic                 out_pcincr,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q;
  logic                 accept, fire;

  assign out_valid   = (state != EMPTY);
  assign out_payload = out_valid ? main_q : NOP_PAYLOAD;

  // Skid mode breaks the ready path with a register; single-entry mode
  // lets a draining consumer admit a new entry in the same cycle.
  assign in_ready = SKID ? ready_q : (out_ready | ~out_valid);
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;

  always_comb begin
    next_state = state;
    main_d     = main_q;
    skid_d     = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          main_d     = in_payload;
        end
      end
      ONE: begin
        if (accept) begin
          if (SKID && !fire) begin
            next_state = FULL;
            skid_d     = in_payload;
          end else begin
            main_d = in_payload;
          end
        end else if (fire) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          next_state = ONE;
          main_d     = skid_q;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
    if (flush) begin
      next_state = EMPTY;
      main_d     = NOP_PAYLOAD;
      skid_d     = NOP_PAYLOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      main_q  <= NOP_PAYLOAD;
      skid_q  <= NOP_PAYLOAD;
      ready_q <= 1'b1;
    end else begin
      state   <= next_state;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (next_state != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pcincr <= 1'b1;
    end else begin
      out_pcincr <= in_pcincr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;

  localparam int W = 96;
  localparam logic [W-1:0] NOP = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: skid mode, default counter
  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [W-1:0] a_in_payload = '0, a_out_payload;
  logic         a_flush = 1'b0, a_in_pcincr = 1'b1, a_out_pcincr, a_stall_clr = 1'b0;
  logic [15:0]  a_stall_cnt;
  // DUT B: single-entry mode
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [W-1:0] b_in_payload = '0, b_out_payload;
  logic         b_flush = 1'b0, b_in_pcincr = 1'b1, b_out_pcincr, b_stall_clr = 1'b0;
  logic [15:0]  b_stall_cnt;
  // DUT C: skid mode, 4-bit counter
  logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
  logic [W-1:0] c_in_payload = '0, c_out_payload;
  logic         c_flush = 1'b0, c_in_pcincr = 1'b1, c_out_pcincr, c_stall_clr = 1'b0;
  logic [3:0]   c_stall_cnt;

  pipeline_stage_reg #(.PAYLOAD_W(W), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_payload(a_in_payload), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_payload(a_out_payload), .flush(a_flush), .in_pcincr(a_in_pcincr),
    .out_pcincr(a_out_pcincr), .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr));

  pipeline_stage_reg #(.PAYLOAD_W(W), .SKID(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_payload(b_in_payload), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_payload(b_out_payload), .flush(b_flush), .in_pcincr(b_in_pcincr),
    .out_pcincr(b_out_pcincr), .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr));

  pipeline_stage_reg #(.PAYLOAD_W(W), .SKID(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_payload(c_in_payload), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_payload(c_out_payload), .flush(c_flush), .in_pcincr(c_in_pcincr),
    .out_pcincr(c_out_pcincr), .stall_cnt(c_stall_cnt), .stall_clr(c_stall_clr));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] p;
    logic         ordy;
    logic         fl;
    logic         clr;
    logic         ev;
    logic [W-1:0] ep;
    logic         erdy;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [W-1:0] p, logic ordy, logic fl, logic clr,
                              logic ev, logic [W-1:0] ep, logic erdy, logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.p = p; r.ordy = ordy; r.fl = fl; r.clr = clr;
    r.ev = ev; r.ep = ep; r.erdy = erdy; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pc;

    // Streaming 1..8 with out_ready high
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b1, W'(k), 1'b1, 1'b0, 1'b0, 1'b1, W'(k), 1'b1, 16'd0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 16'd0));
    // Skid fill: A loaded, B goes to skid, C held off while in_ready=0
    tbl.push_back(mk(1'b1, W'(8'hA), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hA), 1'b1, 16'd0));
    tbl.push_back(mk(1'b1, W'(8'hB), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hA), 1'b0, 16'd1));
    tbl.push_back(mk(1'b1, W'(8'hC), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hA), 1'b0, 16'd2));
    tbl.push_back(mk(1'b1, W'(8'hC), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hA), 1'b0, 16'd3));
    // Release: A fires (C still refused), then C accepted as B fires
    tbl.push_back(mk(1'b1, W'(8'hC), 1'b1, 1'b0, 1'b0, 1'b1, W'(8'hB), 1'b1, 16'd3));
    tbl.push_back(mk(1'b1, W'(8'hC), 1'b1, 1'b0, 1'b0, 1'b1, W'(8'hC), 1'b1, 16'd3));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 16'd3));
    // Fill to FULL then flush with a simultaneous incoming 0xD
    tbl.push_back(mk(1'b1, W'(8'hE), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hE), 1'b1, 16'd3));
    tbl.push_back(mk(1'b1, W'(8'hF), 1'b0, 1'b0, 1'b0, 1'b1, W'(8'hE), 1'b0, 16'd4));
    tbl.push_back(mk(1'b1, W'(8'hD), 1'b0, 1'b1, 1'b0, 1'b0, NOP, 1'b1, 16'd5));
    tbl.push_back(mk(1'b0, W'(8'hD), 1'b1, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 16'd5));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 1'b1, 16'd0));

    // Reset state
    #12;
    check("rst.a_valid", W'(a_out_valid), W'(1'b0));
    check("rst.a_payload", a_out_payload, NOP);
    check("rst.a_ready", W'(a_in_ready), W'(1'b1));
    check("rst.a_pcincr", W'(a_out_pcincr), W'(1'b1));
    check("rst.a_cnt", W'(a_stall_cnt), W'(16'd0));
    check("rst.b_ready", W'(b_in_ready), W'(1'b1));
    check("rst.b_valid", W'(b_out_valid), W'(1'b0));
    check("rst.c_cnt", W'(c_stall_cnt), W'(4'd0));
    #5 rst = 1'b1;

    // Table-driven run on the skid-mode stage
    for (int i = 0; i < tbl.size(); i++) begin
      pc = ((i % 3) == 1);
      a_in_valid   = tbl[i].v;
      a_in_payload = tbl[i].p;
      a_out_ready  = tbl[i].ordy;
      a_flush      = tbl[i].fl;
      a_stall_clr  = tbl[i].clr;
      a_in_pcincr  = pc;
      tick();
      check($sformatf("vec%0d.valid", i), W'(a_out_valid), W'(tbl[i].ev));
      check($sformatf("vec%0d.payload", i), a_out_payload, tbl[i].ep);
      check($sformatf("vec%0d.ready", i), W'(a_in_ready), W'(tbl[i].erdy));
      check($sformatf("vec%0d.cnt", i), W'(a_stall_cnt), W'(tbl[i].ecnt));
      check($sformatf("vec%0d.pcincr", i), W'(a_out_pcincr), W'(pc));
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_stall_clr = 1'b0; a_out_ready = 1'b1;

    // Single-entry mode backpressure and replacement
    b_in_valid = 1'b1; b_in_payload = W'(8'h5); b_out_ready = 1'b0;
    tick();
    check("b.load5.valid", W'(b_out_valid), W'(1'b1));
    check("b.load5.payload", b_out_payload, W'(8'h5));
    b_in_valid = 1'b0;
    #1 check("b.stall.ready_comb", W'(b_in_ready), W'(1'b0));
    tick();
    check("b.held.payload", b_out_payload, W'(8'h5));
    check("b.held.cnt", W'(b_stall_cnt), W'(16'd1));
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_payload = W'(8'h6);
    #1 check("b.release.ready_comb", W'(b_in_ready), W'(1'b1));
    tick();
    check("b.replace.payload", b_out_payload, W'(8'h6));
    check("b.replace.valid", W'(b_out_valid), W'(1'b1));
    b_in_payload = W'(8'h7);
    tick();
    check("b.stream.payload", b_out_payload, W'(8'h7));
    b_flush = 1'b1; b_in_payload = W'(8'h9);
    tick();
    check("b.flush.valid", W'(b_out_valid), W'(1'b0));
    check("b.flush.payload", b_out_payload, NOP);
    check("b.flush.cnt", W'(b_stall_cnt), W'(16'd1));
    b_flush = 1'b0; b_in_valid = 1'b0;
    tick();
    check("b.idle.valid", W'(b_out_valid), W'(1'b0));

    // Counter saturation and clear with CNT_W=4
    c_in_valid = 1'b1; c_in_payload = W'(8'h11); c_out_ready = 1'b0;
    tick();
    c_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("c.sat.cnt", W'(c_stall_cnt), W'(4'd15));
    check("c.sat.payload", c_out_payload, W'(8'h11));
    c_stall_clr = 1'b1;
    tick();
    check("c.clr.cnt", W'(c_stall_cnt), W'(4'd0));
    c_stall_clr = 1'b0;
    tick();
    check("c.after_clr.cnt", W'(c_stall_cnt), W'(4'd1));

    // Asynchronous reset mid-operation, then first edge behaves as EMPTY
    a_in_valid = 1'b1; a_in_payload = W'(8'h42); a_out_ready = 1'b0;
    tick();
    check("a.pre_rst.payload", a_out_payload, W'(8'h42));
    a_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("a.mid_rst.valid", W'(a_out_valid), W'(1'b0));
    check("a.mid_rst.payload", a_out_payload, NOP);
    check("a.mid_rst.ready", W'(a_in_ready), W'(1'b1));
    check("a.mid_rst.cnt", W'(a_stall_cnt), W'(16'd0));
    check("c.mid_rst.cnt", W'(c_stall_cnt), W'(4'd0));
    #2 rst = 1'b1;
    a_in_valid = 1'b1; a_in_payload = W'(8'h77);
    tick();
    check("a.post_rst.valid", W'(a_out_valid), W'(1'b1));
    check("a.post_rst.payload", a_out_payload, W'(8'h77));
    check("a.post_rst.ready", W'(a_in_ready), W'(1'b1));
    check("a.post_rst.cnt", W'(a_stall_cnt), W'(16'd0));
    a_in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
